store_handler: RTL and testbench
================================

Name: store_handler

Overview:
- Write-back stage opposite the operand-fetch stage: accepts ALU results with their destination address and commits them to data memory.
- Results are buffered in a small FIFO so the ALU can produce back-to-back results while memory writes drain, at most one write every 2 cycles.
- Exposes an address-hazard check so the fetch side can stall on a read-after-write to a pending destination.

Parameters:
- DATA_WIDTH, 8, width of result and memory data word
- DATA_MEMORY_SIZE, 64, data memory depth in words; ADDR_W = $clog2(DATA_MEMORY_SIZE)
- FIFO_DEPTH, 4, pending-store entries; power of two, >= 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  permits starting new memory writes
- in_valid  in  1  result_in/dst_in valid this cycle
- in_ready  out  1  FIFO can accept; = (count != FIFO_DEPTH)
- result_in  in  DATA_WIDTH  value to store
- dst_in  in  ADDR_W  destination address
- mem_addr  out  ADDR_W  write address to data memory
- mem_data  out  DATA_WIDTH  write data to data memory
- mem_we  out  1  memory write enable; memory writes on the posedge ending a mem_we=1 cycle
- done  out  1  one-cycle pulse per committed store
- busy  out  1  count != 0 or state != IDLE
- count  out  $clog2(FIFO_DEPTH+1)  valid FIFO entries
- hazard_addr  in  ADDR_W  address the fetch side is about to read
- hazard  out  1  combinational; 1 if any valid FIFO entry has dst == hazard_addr

Behaviour:
- Reset: count=0, pointers=0, state=IDLE, mem_addr=0, mem_data=0, mem_we=0, done=0, all FIFO valid flags cleared. Reset overrides every other input, including during a write.
- Push: in_valid & in_ready at posedge -> {dst_in, result_in} written at tail; tail wraps modulo FIFO_DEPTH.
- in_valid while full: ignored, no state change, no error flag.
- States:
  - IDLE: if enable & count!=0 at posedge -> WRITE. On that edge, load mem_addr/mem_data from head and set mem_we=1.
  - WRITE: lasts exactly one cycle with mem_we=1. The head entry stays in the FIFO, so hazard still covers it. At the next posedge -> DONE: mem_we=0, done=1, head popped, count decremented.
  - DONE: lasts one cycle with done=1. At the next posedge:
    - if enable & count!=0 -> WRITE with the new head;
    - else -> IDLE with done=0.
- Latency: a push at edge N gives mem_we high in cycle N+1..N+2 and done high in cycle N+2..N+3. Sustained throughput is 1 store per 2 cycles.
- Simultaneous push and pop on one edge: both take effect; count unchanged.
- Full FIFO with a pop on this edge: in_ready is still 0 this cycle (no bypass); it rises the cycle after.
- enable low: no new WRITE starts; a WRITE already in progress completes through DONE. FIFO keeps accepting pushes.
- mem_addr/mem_data hold their last value outside WRITE; only mem_we qualifies them.
- Stores commit in strict FIFO order. Two pending stores to the same address: the later one wins in memory.
- hazard is purely combinational on the valid flags, stored dst values and hazard_addr. It drops on the edge that pops the matching entry, which is the same edge the memory write lands.

Decomposition:
- Shared package: ADDR_W derivation and the state encoding (IDLE, WRITE, DONE) as localparams.
- Natural sub-module: store_fifo. It holds {addr, data} storage, per-entry valid flags, head/tail pointers and count. It provides push/pop ports, head outputs and a per-entry match vector used for hazard.
- Top level keeps only the FSM and the output registers.

Test Plan:
- Single store: reset, enable=1, push result 0x5A to addr 12 -> mem_we=1 with mem_addr=12, mem_data=0x5A for exactly one cycle, done pulse the next cycle, count returns to 0, busy falls.
- Burst to full: push 0x11,0x22,0x33,0x44,0x55 to addrs 1-5 on consecutive cycles (DEPTH 4) -> writes commit in order 1,2,3,4 (the 5th push is accepted once space frees) and in_ready=0 during full cycles. If the 5th push was dropped while full, it must not be committed; confirm per cycle.
- Hazard: push to addr 7, set hazard_addr=7 -> hazard=1 through the WRITE cycle and 0 from the done cycle onward; hazard_addr=8 -> hazard=0 throughout.
- enable gating: fill 2 entries with enable=0 -> mem_we stays 0 and count=2; raise enable -> two writes 2 cycles apart. Drop enable during the first WRITE -> that write completes, the second does not start.
- Simultaneous push/pop: push on the same edge as DONE entry -> count unchanged, the new entry is written later in order.
- Reset mid-write: assert rst during WRITE -> next cycle mem_we=0, done=0, count=0, hazard=0; the old entries are never written after reset.

Source files
------------

// File: rtl/store_handler_pkg.sv
// Shared definitions for the store_handler write-back stage: width helpers and FSM encoding.
package store_handler_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_WRITE_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    // Address width for a memory of the given depth; at least one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Counter width able to hold values 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/store_handler_fifo.sv
// Pending-store FIFO: {addr, data} entries with per-entry valid flags and an address match vector.
module store_handler_fifo
    import store_handler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [ADDR_W-1:0]     i_push_addr,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    input  logic [ADDR_W-1:0]     i_match_addr,
    output logic [ADDR_W-1:0]     o_head_addr,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_full,
    output logic [DEPTH-1:0]      o_match
);

    logic [ADDR_W-1:0]     r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign w_push      = i_push & ~o_full;
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;

    // Payload storage needs no reset; valid flags qualify every entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    // Pointers, count and valid flags; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_match = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_match[i] = r_valid[i] && (r_addr[i] == i_match_addr);
        end
    end

endmodule

// File: rtl/store_handler.sv
// Write-back stage: buffers ALU results and commits them to data memory, one write per two cycles.
module store_handler
    import store_handler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned DATA_MEMORY_SIZE = 64,
    parameter int unsigned FIFO_DEPTH       = 4,
    localparam int unsigned ADDR_W          = addr_width(DATA_MEMORY_SIZE),
    localparam int unsigned CNT_W           = count_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic [ADDR_W-1:0]     dst_in,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_W-1:0]      count,
    input  logic [ADDR_W-1:0]     hazard_addr,
    output logic                  hazard
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_mem_we;
    logic                  r_done;
    logic                  w_mem_we_nxt;
    logic                  w_done_nxt;
    logic                  w_load;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_pending;
    logic [ADDR_W-1:0]     w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [CNT_W-1:0]      w_count;
    logic [FIFO_DEPTH-1:0] w_match;

    // The head entry is popped only when its write lands, so hazard covers it through WRITE.
    assign w_pop     = (r_state == ST_WRITE);
    assign w_push    = in_valid & ~w_full;
    assign w_pending = (w_count != '0);

    store_handler_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_addr  (dst_in),
        .i_push_data  (result_in),
        .i_pop        (w_pop),
        .i_match_addr (hazard_addr),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_match      (w_match)
    );

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_we_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_pending) begin
                    w_state_nxt  = ST_WRITE;
                    w_mem_we_nxt = 1'b1;
                    w_load       = 1'b1;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
            end
            ST_DONE: begin
                if (enable && w_pending) begin
                    w_state_nxt  = ST_WRITE;
                    w_mem_we_nxt = 1'b1;
                    w_load       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers; address/data hold outside WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_we <= w_mem_we_nxt;
            r_done   <= w_done_nxt;
            if (w_load) begin
                r_mem_addr <= w_head_addr;
                r_mem_data <= w_head_data;
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;
    assign done     = r_done;
    assign count    = w_count;
    assign in_ready = ~w_full;
    assign busy     = w_pending | (r_state != ST_IDLE);
    assign hazard   = |w_match;

endmodule

// File: tb/tb_store_handler.sv
// Bench for store_handler: queue-based reference model checked every cycle plus directed literal checks.
module tb_store_handler;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] result_in;
    logic [AW-1:0] dst_in;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic          done;
    logic          busy;
    logic [2:0]    count;
    logic [AW-1:0] hazard_addr;
    logic          hazard;

    int total = 0;
    int bad   = 0;

    store_handler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result_in   (result_in),
        .dst_in      (dst_in),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .done        (done),
        .busy        (busy),
        .count       (count),
        .hazard_addr (hazard_addr),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending stores as a queue, writer as idle / writing / reporting.
    ent_t          mq[$];
    ent_t          mlog[$];
    ent_t          dlog[$];
    int            mphase = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_we   = 1'b0;
    logic          m_done = 1'b0;
    ent_t          m_in;
    ent_t          d_ent;

    always @(posedge clk) begin
        int   sz;
        logic push_ok;
        logic exp_hz;
        if (rst) begin
            mq.delete();
            mphase = 0;
            m_addr = '0;
            m_data = '0;
            m_we   = 1'b0;
            m_done = 1'b0;
        end else begin
            sz      = mq.size();
            push_ok = in_valid && (sz < DEPTH);
            m_in.a  = dst_in;
            m_in.d  = result_in;
            if (mphase == 1) begin
                mlog.push_back(mq.pop_front());
                mphase = 2;
                m_we   = 1'b0;
                m_done = 1'b1;
            end else if (enable && sz > 0) begin
                mphase = 1;
                m_addr = mq[0].a;
                m_data = mq[0].d;
                m_we   = 1'b1;
                m_done = 1'b0;
            end else begin
                mphase = 0;
                m_we   = 1'b0;
                m_done = 1'b0;
            end
            if (push_ok) mq.push_back(m_in);
        end
        #1;
        exp_hz = 1'b0;
        foreach (mq[i]) if (mq[i].a == hazard_addr) exp_hz = 1'b1;
        chk("mem_we",   32'(mem_we),   32'(m_we));
        chk("done",     32'(done),     32'(m_done));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_data", 32'(mem_data), 32'(m_data));
        chk("count",    32'(count),    32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("busy",     32'(busy),     32'((mq.size() != 0) || (mphase != 0)));
        chk("hazard",   32'(hazard),   32'(exp_hz));
    end

    // Memory-side observer: records every committed write; reset overrides a write on its edge.
    always @(posedge clk) begin
        if (!rst && mem_we) begin
            d_ent.a = mem_addr;
            d_ent.d = mem_data;
            dlog.push_back(d_ent);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        dst_in    = a;
        result_in = d;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic push_once(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        in_valid  = 1'b1;
        dst_in    = a;
        result_in = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drop();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int logsz;
        int n9;
        rst         = 1'b1;
        enable      = 1'b0;
        in_valid    = 1'b0;
        result_in   = '0;
        dst_in      = '0;
        hazard_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("reset_count",    32'(count),    32'd0);
        chk("reset_mem_we",   32'(mem_we),   32'd0);
        chk("reset_done",     32'(done),     32'd0);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);

        // Single store.
        enable = 1'b1;
        push(6'd12, 8'h5A);
        drop();
        cyc();
        chk("single_we",   32'(mem_we),   32'd1);
        chk("single_addr", 32'(mem_addr), 32'd12);
        chk("single_data", 32'(mem_data), 32'h5A);
        cyc();
        chk("single_we_off", 32'(mem_we), 32'd0);
        chk("single_done",   32'(done),   32'd1);
        chk("single_count",  32'(count),  32'd0);
        cyc();
        chk("single_done_off", 32'(done), 32'd0);
        chk("single_busy_off", 32'(busy), 32'd0);

        // Burst to full, a dropped push while full, then a push that waits for space.
        @(negedge clk);
        enable = 1'b0;
        push(6'd1, 8'h11);
        push(6'd2, 8'h22);
        push(6'd3, 8'h33);
        push(6'd4, 8'h44);
        #2;
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        push_once(6'd9, 8'h99);
        enable = 1'b1;
        push(6'd5, 8'h55);
        drop();
        repeat (12) cyc();

        // Hazard on a pending destination, then on an unrelated address.
        hazard_addr = 6'd7;
        push(6'd7, 8'h77);
        #2;
        chk("hz_pending", 32'(hazard), 32'd1);
        drop();
        cyc();
        chk("hz_write_we", 32'(mem_we), 32'd1);
        chk("hz_write",    32'(hazard), 32'd1);
        cyc();
        chk("hz_done",     32'(done),   32'd1);
        chk("hz_cleared",  32'(hazard), 32'd0);
        hazard_addr = 6'd8;
        push(6'd7, 8'h78);
        #2;
        chk("hz_other", 32'(hazard), 32'd0);
        drop();
        repeat (4) cyc();

        // enable gating: hold off, then two writes two cycles apart.
        enable = 1'b0;
        push(6'd20, 8'hA0);
        push(6'd21, 8'hA1);
        drop();
        repeat (3) cyc();
        chk("gate_count", 32'(count),  32'd2);
        chk("gate_we",    32'(mem_we), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        cyc();
        chk("gate_w1",      32'(mem_we),   32'd1);
        chk("gate_w1_addr", 32'(mem_addr), 32'd20);
        cyc();
        chk("gate_d1", 32'(done), 32'd1);
        cyc();
        chk("gate_w2",      32'(mem_we),   32'd1);
        chk("gate_w2_addr", 32'(mem_addr), 32'd21);
        cyc();
        cyc();
        chk("gate_empty", 32'(count), 32'd0);

        // Dropping enable mid-write: that write finishes, the next does not start.
        enable = 1'b0;
        push(6'd22, 8'hB0);
        push(6'd23, 8'hB1);
        drop();
        @(negedge clk);
        enable = 1'b1;
        cyc();
        chk("stop_w1_addr", 32'(mem_addr), 32'd22);
        @(negedge clk);
        enable = 1'b0;
        cyc();
        chk("stop_done", 32'(done), 32'd1);
        cyc();
        chk("stop_idle_we", 32'(mem_we), 32'd0);
        chk("stop_count",   32'(count),  32'd1);
        cyc();
        chk("stop_hold_we", 32'(mem_we), 32'd0);
        enable = 1'b1;
        repeat (5) cyc();

        // Push on the same edge as a pop.
        push(6'd30, 8'hC0);
        drop();
        cyc();
        chk("sim_write", 32'(mem_we), 32'd1);
        push(6'd31, 8'hC1);
        #2;
        chk("sim_count", 32'(count), 32'd1);
        chk("sim_done",  32'(done),  32'd1);
        drop();
        repeat (6) cyc();

        // Reset in the middle of a write.
        enable = 1'b0;
        push(6'd40, 8'hD0);
        push(6'd41, 8'hD1);
        push(6'd42, 8'hD2);
        drop();
        hazard_addr = 6'd41;
        logsz = dlog.size();
        @(negedge clk);
        enable = 1'b1;
        cyc();
        chk("rst_pre_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("rst_we",     32'(mem_we), 32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_count",  32'(count),  32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) cyc();
        chk("rst_no_commit", 32'(dlog.size()), 32'(logsz));

        // Commit order against the model and hand-computed entries.
        chk("log_size",  32'(dlog.size()), 32'd14);
        chk("mlog_size", 32'(mlog.size()), 32'd14);
        for (int i = 0; i < dlog.size() && i < mlog.size(); i++) begin
            chk("log_entry", 32'(dlog[i]), 32'(mlog[i]));
        end
        if (dlog.size() >= 14) begin
            chk("log0",  32'(dlog[0]),  32'({6'd12, 8'h5A}));
            chk("log1",  32'(dlog[1]),  32'({6'd1,  8'h11}));
            chk("log4",  32'(dlog[4]),  32'({6'd4,  8'h44}));
            chk("log5",  32'(dlog[5]),  32'({6'd5,  8'h55}));
            chk("log7",  32'(dlog[7]),  32'({6'd7,  8'h78}));
            chk("log11", 32'(dlog[11]), 32'({6'd23, 8'hB1}));
            chk("log13", 32'(dlog[13]), 32'({6'd31, 8'hC1}));
        end
        n9 = 0;
        foreach (dlog[i]) if (dlog[i].a == 6'd9) n9++;
        chk("dropped_push", 32'(n9), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
